fetch_queue: RTL and testbench

Instruction buffer between the PC/fetch stage and the decode stage of the pipelined RV32I core. It captures each fetched instruction together with its PC and PC+4 into a DEPTH-entry FIFO and presents the oldest entry to decode through a valid/ready handshake. When the buffer is full it back-pressures the PC stage, which holds PC. A decode-side flush, issued on a taken branch or jump, discards all buffered entries.

---
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: IF/ID instruction buffer.
// DEPTH-entry FIFO of {instr, pc, pc+4} with valid/ready on both sides.
module fetch_queue #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        InstrF,
    input  logic [DATA_WIDTH-1:0]        PCF,
    input  logic [DATA_WIDTH-1:0]        inc_PCF,
    input  logic                         ValidF,
    output logic                         ReadyF,
    output logic [DATA_WIDTH-1:0]        InstrD,
    output logic [DATA_WIDTH-1:0]        PCD,
    output logic [DATA_WIDTH-1:0]        inc_PCD,
    output logic                         ValidD,
    input  logic                         ReadyD,
    input  logic                         FlushD,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] instr_q [DEPTH];
    logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
    logic [DATA_WIDTH-1:0] inc_q   [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    logic push;
    logic pop;

    // Handshake flags depend only on registered occupancy.
    assign ReadyF = (count_q != FULL);
    assign ValidD = (count_q != '0);

    // Flush dominates both sides of the handshake.
    assign push = ValidF && ReadyF && !FlushD;
    assign pop  = ValidD && ReadyD && !FlushD;

    // Pointer and occupancy bookkeeping; flush clears like a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (FlushD) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    // Entry storage is never cleared; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= InstrF;
            pc_q[wr_ptr]    <= PCF;
            inc_q[wr_ptr]   <= inc_PCF;
        end
    end

    // Head presentation: a NOP bundle whenever the queue is empty.
    always_comb begin
        InstrD  = NOP;
        PCD     = '0;
        inc_PCD = '0;
        if (ValidD) begin
            InstrD  = instr_q[rd_ptr];
            PCD     = pc_q[rd_ptr];
            inc_PCD = inc_q[rd_ptr];
        end
    end

    assign Count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of the fetch_queue buffer.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrF, PCF, inc_PCF;
    logic        ValidF;
    logic        ReadyF;
    logic [31:0] InstrD, PCD, inc_PCD;
    logic        ValidD;
    logic        ReadyD;
    logic        FlushD;
    logic [1:0]  Count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(.DEPTH(2), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .InstrF(InstrF), .PCF(PCF), .inc_PCF(inc_PCF),
        .ValidF(ValidF), .ReadyF(ReadyF),
        .InstrD(InstrD), .PCD(PCD), .inc_PCD(inc_PCD),
        .ValidD(ValidD), .ReadyD(ReadyD), .FlushD(FlushD),
        .Count(Count)
    );

    always #5 clk = ~clk;

    // Present one fetch entry; the instruction word encodes its PC.
    task automatic offer(input logic v, input logic [31:0] pc);
        ValidF  = v;
        PCF     = pc;
        inc_PCF = pc + 32'd4;
        InstrF  = 32'hC0DE_0000 ^ pc;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        offer(1'b0, 32'h0);
        ReadyD = 1'b0;
        FlushD = 1'b0;
        #1;
        n_cmp++;
        if (Count !== 2'd0 || ValidD !== 1'b0 || ReadyF !== 1'b1) begin
            n_err++;
            $display("FAIL reset_flags: Count=%0d ValidD=%b ReadyF=%b want 0/0/1",
                     Count, ValidD, ReadyF);
        end
        n_cmp++;
        if (InstrD !== NOP || PCD !== 32'h0 || inc_PCD !== 32'h0) begin
            n_err++;
            $display("FAIL reset_head: InstrD=%h PCD=%h inc=%h want %h/0/0",
                     InstrD, PCD, inc_PCD, NOP);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (ValidD !== 1'b0 || ReadyF !== 1'b1 || InstrD !== NOP
                || Count !== 2'd0) begin
                n_err++;
                $display("FAIL idle[%0d]: V=%b R=%b I=%h C=%0d want 0/1/%h/0",
                         i, ValidD, ReadyF, InstrD, Count, NOP);
            end
        end
    endtask

    task automatic test_streaming();
        ReadyD = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(1'b1, 32'(4 * k));
            tick();
            n_cmp++;
            if (ValidD !== 1'b1 || PCD !== 32'(4 * k)
                || inc_PCD !== 32'(4 * k + 4)
                || InstrD !== (32'hC0DE_0000 ^ 32'(4 * k))
                || Count !== 2'd1) begin
                n_err++;
                $display("FAIL stream[%0d]: V=%b PCD=%h inc=%h I=%h C=%0d want PCD=%h C=1",
                         k, ValidD, PCD, inc_PCD, InstrD, Count, 32'(4 * k));
            end
        end
        offer(1'b0, 32'h0);
        tick();
        n_cmp++;
        if (ValidD !== 1'b0 || Count !== 2'd0 || InstrD !== NOP) begin
            n_err++;
            $display("FAIL stream_drain: V=%b C=%0d I=%h want 0/0/NOP",
                     ValidD, Count, InstrD);
        end
    endtask

    task automatic test_fill();
        ReadyD = 1'b0;
        offer(1'b1, 32'h10);
        tick();
        offer(1'b1, 32'h14);
        tick();
        n_cmp++;
        if (Count !== 2'd2 || ReadyF !== 1'b0 || PCD !== 32'h10) begin
            n_err++;
            $display("FAIL fill_full: C=%0d R=%b PCD=%h want 2/0/10",
                     Count, ReadyF, PCD);
        end
        offer(1'b1, 32'h18);
        tick();
        n_cmp++;
        if (Count !== 2'd2 || ReadyF !== 1'b0 || PCD !== 32'h10) begin
            n_err++;
            $display("FAIL fill_refuse: C=%0d R=%b PCD=%h want 2/0/10",
                     Count, ReadyF, PCD);
        end
        ReadyD = 1'b1;
        tick();
        n_cmp++;
        if (Count !== 2'd1 || ReadyF !== 1'b1 || PCD !== 32'h14) begin
            n_err++;
            $display("FAIL fill_pop: C=%0d R=%b PCD=%h want 1/1/14",
                     Count, ReadyF, PCD);
        end
        ReadyD = 1'b0;
        tick();
        n_cmp++;
        if (Count !== 2'd2 || PCD !== 32'h14) begin
            n_err++;
            $display("FAIL fill_accept: C=%0d PCD=%h want 2/14", Count, PCD);
        end
        offer(1'b0, 32'h0);
        ReadyD = 1'b1;
        tick();
        n_cmp++;
        if (Count !== 2'd1 || PCD !== 32'h18 || inc_PCD !== 32'h1C) begin
            n_err++;
            $display("FAIL fill_tail: C=%0d PCD=%h inc=%h want 1/18/1c",
                     Count, PCD, inc_PCD);
        end
        tick();
        n_cmp++;
        if (Count !== 2'd0 || ValidD !== 1'b0) begin
            n_err++;
            $display("FAIL fill_empty: C=%0d V=%b want 0/0", Count, ValidD);
        end
    endtask

    task automatic test_back_to_back();
        ReadyD = 1'b0;
        offer(1'b1, 32'h30);
        tick();
        ReadyD = 1'b1;
        offer(1'b1, 32'h34);
        tick();
        n_cmp++;
        if (Count !== 2'd1 || PCD !== 32'h34
            || InstrD !== (32'hC0DE_0000 ^ 32'h34)) begin
            n_err++;
            $display("FAIL b2b: C=%0d PCD=%h I=%h want 1/34", Count, PCD, InstrD);
        end
        offer(1'b0, 32'h0);
        tick();
        n_cmp++;
        if (Count !== 2'd0 || ValidD !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: C=%0d V=%b want 0/0", Count, ValidD);
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int recv = 0;
        int mcount = 0;
        int budget = 200;
        logic rdy;
        logic p_push, p_pop;
        while (recv < 9 && budget > 0) begin
            budget--;
            rdy = 1'($urandom_range(0, 1));
            ReadyD = rdy;
            offer(sent < 9, 32'h100 + 32'(4 * sent));
            p_push = (sent < 9) && (mcount != 2);
            p_pop  = (mcount != 0) && rdy;
            if (p_pop) begin
                n_cmp++;
                if (PCD !== 32'h100 + 32'(4 * recv)) begin
                    n_err++;
                    $display("FAIL wrap_order[%0d]: PCD=%h want %h",
                             recv, PCD, 32'h100 + 32'(4 * recv));
                end
                recv++;
            end
            tick();
            if (p_push) sent++;
            if (p_push && !p_pop) mcount++;
            if (p_pop && !p_push) mcount--;
            n_cmp++;
            if (Count !== 2'(mcount)) begin
                n_err++;
                $display("FAIL wrap_count: Count=%0d want %0d", Count, mcount);
            end
        end
        n_cmp++;
        if (recv != 9) begin
            n_err++;
            $display("FAIL wrap_timeout: received %0d want 9", recv);
        end
        offer(1'b0, 32'h0);
        ReadyD = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_flush();
        ReadyD = 1'b0;
        offer(1'b1, 32'h40);
        tick();
        offer(1'b1, 32'h44);
        tick();
        offer(1'b1, 32'h48);
        ReadyD = 1'b1;
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        n_cmp++;
        if (Count !== 2'd0 || ValidD !== 1'b0 || ReadyF !== 1'b1
            || InstrD !== NOP || PCD !== 32'h0) begin
            n_err++;
            $display("FAIL flush: C=%0d V=%b R=%b I=%h PCD=%h want 0/0/1/NOP/0",
                     Count, ValidD, ReadyF, InstrD, PCD);
        end
        ReadyD = 1'b0;
        offer(1'b1, 32'h200);
        tick();
        n_cmp++;
        if (Count !== 2'd1 || PCD !== 32'h200 || inc_PCD !== 32'h204) begin
            n_err++;
            $display("FAIL flush_next: C=%0d PCD=%h inc=%h want 1/200/204",
                     Count, PCD, inc_PCD);
        end
        offer(1'b0, 32'h0);
        ReadyD = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        ReadyD = 1'b0;
        offer(1'b1, 32'h300);
        tick();
        offer(1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (Count !== 2'd0 || ValidD !== 1'b0 || ReadyF !== 1'b1
            || InstrD !== NOP) begin
            n_err++;
            $display("FAIL reset_mid: C=%0d V=%b R=%b I=%h want 0/0/1/NOP",
                     Count, ValidD, ReadyF, InstrD);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
